// File: rtl/pong_game_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pong_game_ctrl_if
// Purpose : Signal bundle between the Pong game sequencer and its neighbours
//           (VGA timing, player buttons, ball and paddle draw stages).
// Revision: 1.0 - initial release
// ============================================================================
interface pong_game_ctrl_if;
  logic        vsync;
  logic        btn_start;
  logic        btn_up_l;
  logic        btn_down_l;
  logic        btn_up_r;
  logic        btn_down_r;
  logic        miss_l;
  logic        miss_r;
  logic [10:0] ball_y;
  logic [10:0] paddle_r_y;
  logic        step_up_l;
  logic        step_down_l;
  logic        step_up_r;
  logic        step_down_r;
  logic        ball_en;
  logic        ball_reset;
  logic        serve_dir;
  logic [3:0]  score_l;
  logic [3:0]  score_r;
  logic [2:0]  state;
  logic        winner;

  modport master (
    output vsync, btn_start, btn_up_l, btn_down_l, btn_up_r, btn_down_r,
    output miss_l, miss_r, ball_y, paddle_r_y,
    input  step_up_l, step_down_l, step_up_r, step_down_r,
    input  ball_en, ball_reset, serve_dir, score_l, score_r, state, winner
  );

  modport slave (
    input  vsync, btn_start, btn_up_l, btn_down_l, btn_up_r, btn_down_r,
    input  miss_l, miss_r, ball_y, paddle_r_y,
    output step_up_l, step_down_l, step_up_r, step_down_r,
    output ball_en, ball_reset, serve_dir, score_l, score_r, state, winner
  );
endinterface
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pong_game_ctrl
// Purpose : Pong match sequencer: match FSM, scores, serve delay and
//           per-frame paddle step strobes. Define AI_RIGHT_EN to let the
//           right paddle track the ball instead of its buttons.
// Revision: 1.0 - initial release
// ============================================================================
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int AI_DEADBAND  = 8
) (
  input  logic            clk,
  input  logic            rst,
  pong_game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [3:0] c_win_score  = 4'(WIN_SCORE);
  localparam logic [7:0] c_serve_last = 8'(SERVE_FRAMES - 1);

  // Synchronizer bit order: {start, up_l, down_l, up_r, down_r}
  logic [4:0] r_btn_s1, r_btn_s2;
  logic       r_start_d, r_start_edge;
  logic       r_vs_s1, r_vs_s2, r_frame_tick;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_serve_cnt, w_serve_cnt_nxt;
  logic [3:0] r_score_l, r_score_r, w_score_l_nxt, w_score_r_nxt;
  logic       r_serve_dir, w_serve_dir_nxt;
  logic       r_winner, w_winner_nxt;
  logic       w_ball_reset_nxt;
  logic       r_ball_en, r_ball_reset;
  logic       r_step_up_l, r_step_down_l, r_step_up_r, r_step_down_r;
  logic       w_step_en, w_up_r, w_down_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_btn_s1     <= '0;
      r_btn_s2     <= '0;
      r_start_d    <= 1'b0;
      r_start_edge <= 1'b0;
      r_vs_s1      <= 1'b0;
      r_vs_s2      <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_btn_s1     <= {bus.btn_start, bus.btn_up_l, bus.btn_down_l,
                       bus.btn_up_r, bus.btn_down_r};
      r_btn_s2     <= r_btn_s1;
      r_start_d    <= r_btn_s2[4];
      r_start_edge <= r_btn_s2[4] & ~r_start_d;
      r_vs_s1      <= bus.vsync;
      r_vs_s2      <= r_vs_s1;
      r_frame_tick <= r_vs_s1 & ~r_vs_s2;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_serve_cnt_nxt  = r_serve_cnt;
    w_score_l_nxt    = r_score_l;
    w_score_r_nxt    = r_score_r;
    w_serve_dir_nxt  = r_serve_dir;
    w_winner_nxt     = r_winner;
    w_ball_reset_nxt = 1'b0;
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (r_state == ST_IDLE) begin
          w_score_l_nxt = '0;
          w_score_r_nxt = '0;
        end
        if (r_start_edge) begin
          w_score_l_nxt    = '0;
          w_score_r_nxt    = '0;
          w_serve_dir_nxt  = 1'b1;
          w_serve_cnt_nxt  = '0;
          w_ball_reset_nxt = 1'b1;
          w_state_nxt      = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (r_frame_tick) begin
          if (r_serve_cnt == c_serve_last) begin
            w_serve_cnt_nxt = '0;
            w_state_nxt     = ST_PLAY;
          end else begin
            w_serve_cnt_nxt = r_serve_cnt + 8'd1;
          end
        end
      end
      ST_PLAY: begin
        // A double miss is a replay: nobody scores, ball goes back to serve
        if (bus.miss_l && bus.miss_r) begin
          w_ball_reset_nxt = 1'b1;
          w_serve_cnt_nxt  = '0;
          w_state_nxt      = ST_SERVE;
        end else if (bus.miss_l) begin
          if (r_score_r != c_win_score) w_score_r_nxt = r_score_r + 4'd1;
          w_serve_dir_nxt = 1'b0;
          w_state_nxt     = ST_POINT;
        end else if (bus.miss_r) begin
          if (r_score_l != c_win_score) w_score_l_nxt = r_score_l + 4'd1;
          w_serve_dir_nxt = 1'b1;
          w_state_nxt     = ST_POINT;
        end
      end
      ST_POINT: begin
        if (r_score_l == c_win_score || r_score_r == c_win_score) begin
          w_winner_nxt = (r_score_r == c_win_score);
          w_state_nxt  = ST_OVER;
        end else begin
          w_ball_reset_nxt = 1'b1;
          w_serve_cnt_nxt  = '0;
          w_state_nxt      = ST_SERVE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_serve_cnt  <= '0;
      r_score_l    <= '0;
      r_score_r    <= '0;
      r_serve_dir  <= 1'b1;
      r_winner     <= 1'b0;
      r_ball_en    <= 1'b0;
      r_ball_reset <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_serve_cnt  <= w_serve_cnt_nxt;
      r_score_l    <= w_score_l_nxt;
      r_score_r    <= w_score_r_nxt;
      r_serve_dir  <= w_serve_dir_nxt;
      r_winner     <= w_winner_nxt;
      r_ball_en    <= (w_state_nxt == ST_PLAY);
      r_ball_reset <= w_ball_reset_nxt;
    end
  end

  assign w_step_en = r_frame_tick && (r_state == ST_SERVE || r_state == ST_PLAY);

`ifdef AI_RIGHT_EN
  localparam logic signed [11:0] c_deadband = 12'(AI_DEADBAND);
  logic signed [11:0] w_ai_d;
  logic               w_unused_btn;
  assign w_ai_d       = $signed({1'b0, bus.ball_y}) - $signed({1'b0, bus.paddle_r_y});
  assign w_up_r       = (w_ai_d < -c_deadband);
  assign w_down_r     = (w_ai_d > c_deadband);
  assign w_unused_btn = ^r_btn_s2[1:0];
`else
  logic w_unused_ai;
  assign w_up_r      = r_btn_s2[1] & ~r_btn_s2[0];
  assign w_down_r    = r_btn_s2[0] & ~r_btn_s2[1];
  assign w_unused_ai = ^{bus.ball_y, bus.paddle_r_y};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_step_up_l   <= 1'b0;
      r_step_down_l <= 1'b0;
      r_step_up_r   <= 1'b0;
      r_step_down_r <= 1'b0;
    end else begin
      r_step_up_l   <= w_step_en & r_btn_s2[3] & ~r_btn_s2[2];
      r_step_down_l <= w_step_en & r_btn_s2[2] & ~r_btn_s2[3];
      r_step_up_r   <= w_step_en & w_up_r;
      r_step_down_r <= w_step_en & w_down_r;
    end
  end

  assign bus.step_up_l   = r_step_up_l;
  assign bus.step_down_l = r_step_down_l;
  assign bus.step_up_r   = r_step_up_r;
  assign bus.step_down_r = r_step_down_r;
  assign bus.ball_en     = r_ball_en;
  assign bus.ball_reset  = r_ball_reset;
  assign bus.serve_dir   = r_serve_dir;
  assign bus.score_l     = r_score_l;
  assign bus.score_r     = r_score_r;
  assign bus.state       = r_state;
  assign bus.winner      = r_winner;

endmodule
`default_nettype wire

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game sequencer for the Pong design. Owns the match state machine (idle, serve, play, point, game over), both score counters and the serve delay. It gates paddle motion to one step request per video frame for each paddle. It sits between the VGA timing stage, the player buttons and the ball and paddle draw stages, driving their enable and step strobes.

## Interface
Parameters:
- WIN_SCORE, 9: points needed to win; legal range 1..15.
- SERVE_FRAMES, 60: frames spent in SERVE before the ball is released; legal range 1..255.
- AI_DEADBAND, 8: in AI mode, pixel tolerance before the right paddle moves.

Ports:
- clk  in  1  system/pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- vsync  in  1  VGA vertical sync from the timing stage.
- btn_start  in  1  start button; asynchronous.
- btn_up_l / btn_down_l  in  1 each  left player buttons; asynchronous.
- btn_up_r / btn_down_r  in  1 each  right player buttons; asynchronous.
- miss_l / miss_r  in  1 each  one-cycle pulses from the ball stage: ball passed the left or right edge.
- ball_y  in  11  ball top y; used only with AI_RIGHT_EN.
- paddle_r_y  in  11  right paddle top y; used only with AI_RIGHT_EN.
- step_up_l / step_down_l / step_up_r / step_down_r  out  1 each  one-cycle paddle step strobes.
- ball_en  out  1  ball may move. High only in PLAY.
- ball_reset  out  1  one-cycle pulse that recentres the ball.
- serve_dir  out  1  ball direction at serve: 0 = toward left, 1 = toward right.
- score_l / score_r  out  4 each  current scores.
- state  out  3  encoded state: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
- winner  out  1  0 = left, 1 = right. Valid only in OVER.

## Operation
- Input conditioning:
  - All five buttons pass through a 2-flop synchronizer.
  - btn_start is edge-detected after synchronization: start_edge = sync & ~sync_d.
  - vsync is edge-detected the same way. The registered rising-edge pulse is frame_tick.
- State machine:
  - IDLE: scores held at 0, ball_en=0. On start_edge: clear scores, set serve_dir=1, pulse ball_reset, go to SERVE.
  - SERVE: serve_cnt counts frame_ticks. When frame_tick arrives with serve_cnt == SERVE_FRAMES-1, clear serve_cnt and go to PLAY.
  - PLAY: ball_en=1.
    - miss_l alone: score_r += 1, serve_dir=0 (toward the loser), go to POINT.
    - miss_r alone: score_l += 1, serve_dir=1, go to POINT.
    - miss_l and miss_r in the same cycle: no score change, serve_dir unchanged, pulse ball_reset, go to SERVE (replay).
  - POINT, one cycle:
    - If score_l == WIN_SCORE or score_r == WIN_SCORE: latch winner and go to OVER.
    - Otherwise pulse ball_reset and go to SERVE.
  - OVER: ball_en=0, scores frozen. On start_edge: same actions as the IDLE start.
- Miss pulses outside PLAY are ignored.
- Scores never exceed WIN_SCORE and never wrap.
- Paddle steps:
  - Step strobes are issued only on frame_tick and only in SERVE or PLAY.
  - step_up_x = synced up button & ~synced down button; step_down_x is the mirror.
  - Both buttons held, or neither: no strobe.
  - This module does no position clamping; the paddle stage clamps.
- Mid-operation reset (rst=0 in any state): next state IDLE and all outputs at reset values. An in-flight serve count is discarded.

## Timing
- Every output is registered.
- Reset values: state=IDLE, all strobes=0, ball_en=0, ball_reset=0, serve_dir=1, scores=0, winner=0, serve_cnt=0.
- Button to synchronized value: 2 cycles. Start press to state==SERVE: 4 cycles (2 sync, 1 edge, 1 FSM).
- vsync rising edge to frame_tick: 2 cycles. frame_tick to step strobe: 1 cycle. Each strobe is exactly 1 cycle wide, at most one per frame per paddle.
- miss pulse in PLAY to score update and state==POINT: 1 cycle. POINT to SERVE or OVER: 1 cycle.
- ball_reset is high for exactly the cycle in which state first reads SERVE.
- The serve delay is exactly SERVE_FRAMES frame_ticks counted inside SERVE.
- ball_en falls in the cycle state leaves PLAY.

## Configuration
- AI_RIGHT_EN defined: btn_up_r and btn_down_r are ignored. On each qualifying frame_tick the right paddle is driven from the ball position, using 12-bit signed difference d = ball_y - paddle_r_y:
  - step_up_r = 1 when d < -AI_DEADBAND.
  - step_down_r = 1 when d > AI_DEADBAND.
  - No strobe otherwise.
- AI_RIGHT_EN undefined: the right paddle follows its buttons. ball_y and paddle_r_y are left unconnected internally.

## Test plan
- Reset and start: hold rst=0 for 5 cycles and check all reset values. Pulse btn_start → state=SERVE 4 cycles later, one ball_reset pulse, scores 0/0.
- Serve delay: SERVE_FRAMES=3 with vsync pulses → state=PLAY one cycle after the 3rd frame_tick, ball_en=1.
- Scoring to win: WIN_SCORE=2, two miss_r pulses in PLAY (each followed by a serve) → score_l=2, state=OVER, winner=0. A further miss_r changes nothing. btn_start → scores 0/0, SERVE.
- Simultaneous miss: miss_l and miss_r in the same cycle → scores unchanged, ball_reset pulse, state=SERVE.
- Paddle strobes: hold btn_up_l across 3 frames → exactly 3 one-cycle step_up_l pulses. Hold btn_up_l and btn_down_l together → none. No strobes in IDLE or OVER.
- AI mode (AI_RIGHT_EN): ball_y=300, paddle_r_y=200 → step_down_r each frame. ball_y=204, paddle_r_y=200 → no strobe.
